// File: rtl/gpio_irq_pkg10.sv
// GPIO interrupt subunit shared definitions: register map,
// reset values, TYPE/POL encodings and the trigger helper.
package gpio_irq_pkg10;

  localparam logic [5:0] ADDR_DIR    = 6'h04;
  localparam logic [5:0] ADDR_OE     = 6'h08;
  localparam logic [5:0] ADDR_OUT    = 6'h0C;
  localparam logic [5:0] ADDR_IN     = 6'h10;
  localparam logic [5:0] ADDR_MASK   = 6'h14;
  localparam logic [5:0] ADDR_TYPE   = 6'h18;
  localparam logic [5:0] ADDR_POL    = 6'h1C;
  localparam logic [5:0] ADDR_STATUS = 6'h20;
  localparam logic [5:0] ADDR_DBLIM  = 6'h24;

  localparam logic RST_BIT = 1'b0;

  localparam logic TYPE_LEVEL = 1'b0;
  localparam logic TYPE_EDGE  = 1'b1;
  localparam logic POL_LOW    = 1'b0;
  localparam logic POL_HIGH   = 1'b1;

  function automatic logic trig_bit(
    input logic typ,
    input logic pol,
    input logic cur,
    input logic prev
  );
    if (typ == TYPE_EDGE)
      return (cur == pol) && (cur != prev);
    return (cur == pol);
  endfunction

endpackage

// File: rtl/gpio_debounce10.sv
// Single-pin debouncer. Ports: pclk10, n_reset10, sync_in (synchronised pin),
// in_q (current IN bit), dblim, filt_out (next IN bit). Macro: GPIO_DEBOUNCE_EN.
module gpio_debounce10
  import gpio_irq_pkg10::*;
#(
  parameter int DB_W = 8
) (
  input  logic            pclk10,
  input  logic            n_reset10,
  input  logic            sync_in,
  input  logic            in_q,
  input  logic [DB_W-1:0] dblim,
  output logic            filt_out
);

`ifdef GPIO_DEBOUNCE_EN
  logic [DB_W-1:0] cnt;
  logic            diff;

  // A 1-bit input that changes while differing from IN becomes equal
  // to IN, so clearing on !diff also restarts on any change.
  assign diff = sync_in ^ in_q;

  always_ff @(posedge pclk10 or negedge n_reset10) begin
    if (!n_reset10)
      cnt <= {DB_W{RST_BIT}};
    else if (!diff)
      cnt <= {DB_W{RST_BIT}};
    else if (cnt != {DB_W{1'b1}})
      cnt <= cnt + 1'b1;
  end

  // cnt holds (cycles different - 1), so release after dblim+1 cycles.
  assign filt_out = (diff && (cnt >= dblim)) ? sync_in : in_q;
`else
  logic unused_db;
  assign unused_db = ^{pclk10, n_reset10, in_q, dblim};
  assign filt_out  = sync_in;
`endif

endmodule

// File: rtl/gpio_irq_subunit10.sv
// GPIO block with synchroniser, optional debounce and per-pin interrupts.
// Ports: pclk10/n_reset10, read/write/addr/wdata10/rdata10 register bus,
// pin_in10, tri_state_enable10, pin_out10, pin_oe_n10, interrupt10, irq_any.
// Macro GPIO_DEBOUNCE_EN enables the debouncer and the DBLIM register.
module gpio_irq_subunit10
  import gpio_irq_pkg10::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic             pclk10,
  input  logic             n_reset10,
  input  logic             read,
  input  logic             write,
  input  logic [5:0]       addr,
  input  logic [WIDTH-1:0] wdata10,
  input  logic [WIDTH-1:0] pin_in10,
  input  logic [WIDTH-1:0] tri_state_enable10,
  output logic [WIDTH-1:0] rdata10,
  output logic [WIDTH-1:0] pin_out10,
  output logic [WIDTH-1:0] pin_oe_n10,
  output logic [WIDTH-1:0] interrupt10,
  output logic             irq_any
);

  localparam logic [WIDTH-1:0] RST_W = {WIDTH{RST_BIT}};

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] dir_q, oe_q, out_q, mask_q;
  logic [WIDTH-1:0] type_q, pol_q, stat_q;
  logic [WIDTH-1:0] in_q, prev_q, db_out;
  logic [WIDTH-1:0] trig, rd_mux;
  logic [DB_W-1:0]  dblim_q;
  logic             clr;

  always_ff @(posedge pclk10 or negedge n_reset10) begin
    if (!n_reset10) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= RST_W;
    end else begin
      sync_q[0] <= pin_in10;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    gpio_debounce10 #(
      .DB_W(DB_W)
    ) u_db (
      .pclk10   (pclk10),
      .n_reset10(n_reset10),
      .sync_in  (sync_q[SYNC_STAGES-1][g]),
      .in_q     (in_q[g]),
      .dblim    (dblim_q),
      .filt_out (db_out[g])
    );
  end

`ifdef GPIO_DEBOUNCE_EN
  always_ff @(posedge pclk10 or negedge n_reset10) begin
    if (!n_reset10)
      dblim_q <= {DB_W{RST_BIT}};
    else if (write && (addr == ADDR_DBLIM))
      dblim_q <= DB_W'(wdata10);
  end
`else
  assign dblim_q = {DB_W{RST_BIT}};
`endif

  always_comb begin
    trig = RST_W;
    for (int i = 0; i < WIDTH; i++)
      trig[i] = dir_q[i] &
        trig_bit(type_q[i], pol_q[i], in_q[i], prev_q[i]);
  end

  assign clr = read && (addr == ADDR_STATUS);

  always_ff @(posedge pclk10 or negedge n_reset10) begin
    if (!n_reset10) begin
      dir_q  <= RST_W;
      oe_q   <= RST_W;
      out_q  <= RST_W;
      mask_q <= RST_W;
      type_q <= RST_W;
      pol_q  <= RST_W;
      stat_q <= RST_W;
      in_q   <= RST_W;
      prev_q <= RST_W;
    end else begin
      in_q   <= db_out;
      prev_q <= in_q;
      // Set dominates clear so a live level source re-arms at once.
      stat_q <= (stat_q & ~{WIDTH{clr}}) | trig;
      if (write) begin
        unique case (addr)
          ADDR_DIR:  dir_q  <= wdata10;
          ADDR_OE:   oe_q   <= wdata10;
          ADDR_OUT:  out_q  <= wdata10;
          ADDR_MASK: mask_q <= wdata10;
          ADDR_TYPE: type_q <= wdata10;
          ADDR_POL:  pol_q  <= wdata10;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_mux = RST_W;
    unique case (addr)
      ADDR_DIR:    rd_mux = dir_q;
      ADDR_OE:     rd_mux = oe_q;
      ADDR_OUT:    rd_mux = out_q;
      ADDR_IN:     rd_mux = in_q;
      ADDR_MASK:   rd_mux = mask_q;
      ADDR_TYPE:   rd_mux = type_q;
      ADDR_POL:    rd_mux = pol_q;
      ADDR_STATUS: rd_mux = stat_q;
      ADDR_DBLIM:  rd_mux = WIDTH'(dblim_q);
      default:     rd_mux = RST_W;
    endcase
  end

  always_ff @(posedge pclk10 or negedge n_reset10) begin
    if (!n_reset10)
      rdata10 <= RST_W;
    else
      rdata10 <= read ? rd_mux : RST_W;
  end

  assign pin_out10   = out_q;
  assign pin_oe_n10  = ~(oe_q & ~dir_q) | tri_state_enable10;
  assign interrupt10 = stat_q & mask_q;
  assign irq_any     = |interrupt10;

endmodule

// File: doc/gpio_irq_subunit10.md
GPIO_IRQ_SUBUNIT10 -- requirements
Module: gpio_irq_subunit10

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the GPIO pin count (1..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the input synchroniser depth (2..4).
REQ-003 The block SHALL have parameter DB_W, default 8, meaning the debounce counter width.
REQ-004 pclk10  input  1  clock; all state SHALL be updated on its rising edge.
REQ-005 n_reset10  input  1  reset; asynchronous, active-low.
REQ-006 read / write  input  1 each  register read / write strobe.
REQ-007 addr  input  6  register byte address.
REQ-008 wdata10  input  WIDTH  write data.
REQ-009 pin_in10  input  WIDTH  raw pin inputs (asynchronous).
REQ-010 tri_state_enable10  input  WIDTH  test override; 1 forces the pin output enable inactive.
REQ-011 rdata10  output  WIDTH  registered read data.
REQ-012 pin_out10 / pin_oe_n10  output  WIDTH each  pin value and active-low output enable.
REQ-013 interrupt10  output  WIDTH  per-pin masked interrupt.
REQ-014 irq_any  output  1  OR of interrupt10.

Function
REQ-015 Register map: 0x04 DIR (1=input), 0x08 OE, 0x0C OUT, 0x10 IN (RO), 0x14 MASK, 0x18 TYPE (1=edge, 0=level), 0x1C POL (1=rising/high, 0=falling/low), 0x20 STATUS (RO, read-clear), 0x24 DBLIM (DB_W bits, RW).
REQ-016 A write SHALL update the addressed RW register on the next clock edge; writes to RO or unmapped addresses SHALL be ignored.
REQ-017 rdata10 SHALL present the addressed register one cycle after read=1, SHALL be zero for unmapped addresses, and SHALL be zero in every cycle following read=0.
REQ-018 pin_in10 SHALL pass through SYNC_STAGES flops; IN SHALL be updated from the debouncer output, giving a base latency of SYNC_STAGES+1 cycles from pin to IN.
REQ-019 The block SHALL hold a previous-value register prev_in, which follows IN with a one-cycle delay.
REQ-020 Edge pins (TYPE=1) SHALL trigger when IN differs from prev_in and IN equals POL.
REQ-021 Level pins (TYPE=0) SHALL trigger in every cycle in which IN equals POL.
REQ-022 A trigger SHALL be qualified by DIR=1; output pins SHALL never set STATUS.
REQ-023 STATUS SHALL update as STATUS = (STATUS & ~clr) | trig, where clr is all-ones during a read of 0x20.
REQ-024 When a trigger and a read-clear coincide, the set SHALL win.
REQ-025 Because of REQ-021 and REQ-024, an active level source SHALL re-set its STATUS bit on the cycle after a read-clear.
REQ-026 interrupt10 SHALL equal STATUS & MASK (combinational from registers).
REQ-027 Masked pins SHALL still record STATUS.
REQ-028 pin_out10 SHALL equal OUT.
REQ-029 pin_oe_n10 SHALL equal ~(OE & ~DIR) | tri_state_enable10.

Reset
REQ-030 Asserting n_reset10 SHALL immediately clear all registers, synchroniser flops, prev_in, debounce counters and rdata10 to 0, including during an in-progress debounce or pending interrupt.
REQ-031 Consequently, after reset: pin_out10=0, pin_oe_n10=all-ones, interrupt10=0, irq_any=0.
REQ-032 Because IN and prev_in reset equal, no edge trigger SHALL occur on the first cycles after reset release.

Configuration
REQ-033 Macro GPIO_DEBOUNCE_EN defined: each pin SHALL pass the synchronised value to IN only after it has been stable and different from IN for DBLIM+1 consecutive cycles; any change restarts the counter; the counter saturates and never wraps; DBLIM=0 gives a one-cycle filter.
REQ-034 Macro GPIO_DEBOUNCE_EN undefined: the debouncer SHALL be a wire, DBLIM SHALL read as 0 and ignore writes, and 0x24 SHALL read as 0.

Structure
REQ-035 Package gpio_irq_pkg10 SHALL hold the register address constants, reset-value constants, and the TYPE/POL encodings.
REQ-036 One sub-module gpio_debounce10 (single pin: sync input, DBLIM, filtered output) SHALL be instantiated WIDTH times under a generate.

Verification
REQ-037 Reset then read every register: all 0; pin_oe_n10=16'hFFFF.
REQ-038 Write DIR=0, OE=16'h00FF, OUT=16'h1234: pin_out10=16'h1234, pin_oe_n10=16'hFF00; with tri_state_enable10=16'h0001, pin_oe_n10=16'hFF01.
REQ-039 DIR=1, TYPE=1, POL=1, MASK=16'h0004, debounce off: pin_in10[2] 0->1 -> interrupt10=16'h0004 and irq_any=1 at cycle SYNC_STAGES+2; a 1->0 transition sets nothing; reading 0x20 returns 16'h0004 and clears it.
REQ-040 Level pin 5 with POL=0 held low: STATUS[5] is set; read-clear coincident with the trigger leaves STATUS[5]=1; releasing the pin high followed by a read-clear gives 0.
REQ-041 With GPIO_DEBOUNCE_EN and DBLIM=3: a 3-cycle glitch on pin 0 leaves IN[0] unchanged; a 4-cycle stable level updates IN[0].
REQ-042 Read of 0x3C returns 0, and a write to 0x10 leaves IN unchanged.
